// File: rtl/phinc_pkg.sv
// Shared types, sweep mode constants and the range clamp for the phase-increment controller.
package phinc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2
  } sweep_state_e;

  localparam logic MODE_TRI = 1'b0;
  localparam logic MODE_SAW = 1'b1;

  // 9-bit input so an 8'hFF + 1 result is seen as out of range instead of wrapping
  function automatic logic [7:0] clamp_phinc(input logic [8:0] v,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    if (v < {1'b0, lo})      return lo;
    else if (v > {1'b0, hi}) return hi;
    else                     return v[7:0];
  endfunction

endpackage

// File: rtl/phinc_if.sv
// Host write port for the phase-increment register: valid/ready handshake plus data.
interface phinc_if;
  logic       host_valid;
  logic [7:0] host_data;
  logic       host_ready;

  modport master (output host_valid, output host_data, input host_ready);
  modport slave  (input host_valid, input host_data, output host_ready);
endinterface

// File: rtl/sweep_tick_gen.sv
// Sweep step divider: counts 0..STEP_DIV-1 while enabled and pulses tick on the last count.
module sweep_tick_gen #(
  parameter int STEP_DIV = 10000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CW   = $clog2(STEP_DIV);
  localparam logic [CW-1:0]   LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/phinc_ctrl.sv
// Arbitrated owner of the NCO phase-increment register: host write > btn_dn > btn_up > sweep.
//   state | meaning
//   IDLE  | no sweep; only host and button updates
//   UP    | sweep ascending one step per tick
//   DN    | sweep descending one step per tick (triangle only)
module phinc_ctrl
  import phinc_pkg::*;
#(
  parameter logic [7:0] DEFAULT  = 8'd1,
  parameter logic [7:0] PHI_MIN  = 8'd1,
  parameter logic [7:0] PHI_MAX  = 8'd200,
  parameter int         STEP_DIV = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_dn,
  phinc_if.slave      host,
  input  logic        sweep_en,
  input  logic        sweep_mode,
  output logic [7:0]  phinc,
  output logic        phinc_upd,
  output logic [1:0]  sweep_state
);

  sweep_state_e state_q;
  logic         mode_q;
  logic         en_q;
  logic         ready_q;
  logic         tick;
  logic         fire;
  logic         manual;
  logic         rise;
  logic         step;
  logic [7:0]   nxt;

  assign fire        = host.host_valid && ready_q;
  assign manual      = fire || btn_up || btn_dn;
  assign rise        = sweep_en && !en_q;
  // a tick landing in the cycle sweep_en drops is discarded along with the sweep
  assign step        = tick && sweep_en && !manual;
  assign host.host_ready = ready_q;
  assign sweep_state = state_q;

  sweep_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state_q != IDLE),
    .clr   (rise),
    .tick  (tick)
  );

  always_comb begin
    nxt = phinc;
    if (fire) begin
      nxt = clamp_phinc({1'b0, host.host_data}, PHI_MIN, PHI_MAX);
    end else if (btn_dn) begin
      nxt = (phinc > PHI_MIN) ? phinc - 8'd1 : PHI_MIN;
    end else if (btn_up) begin
      nxt = clamp_phinc({1'b0, phinc} + 9'd1, PHI_MIN, PHI_MAX);
    end else if (step) begin
      case (state_q)
        UP: begin
          if (phinc >= PHI_MAX) nxt = (mode_q == MODE_SAW) ? PHI_MIN : phinc - 8'd1;
          else                  nxt = phinc + 8'd1;
        end
        DN: begin
          if (phinc <= PHI_MIN) nxt = phinc + 8'd1;
          else                  nxt = phinc - 8'd1;
        end
        default: nxt = phinc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phinc     <= DEFAULT;
      phinc_upd <= 1'b0;
      ready_q   <= 1'b1;
      state_q   <= IDLE;
      mode_q    <= MODE_TRI;
      en_q      <= 1'b0;
    end else begin
      en_q      <= sweep_en;
      ready_q   <= !fire;
      phinc     <= nxt;
      phinc_upd <= (nxt != phinc);
      if (!sweep_en || manual) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (rise) begin
            state_q <= UP;
            mode_q  <= sweep_mode;
          end
          UP:      if (step && phinc == PHI_MAX && mode_q == MODE_TRI) state_q <= DN;
          DN:      if (step && phinc == PHI_MIN) state_q <= UP;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phinc_ctrl.sv
// Drives two differently parameterised controllers with shared stimulus and compares each against a rule-level model.
module tb_phinc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       btn_up = 1'b0, btn_dn = 1'b0, sweep_en = 1'b0, sweep_mode = 1'b0;
  logic [7:0] phinc_a, phinc_b;
  logic       upd_a, upd_b;
  logic [1:0] st_a, st_b;

  phinc_if ifa();
  phinc_if ifb();

  phinc_ctrl #(.DEFAULT(8'd1), .PHI_MIN(8'd1), .PHI_MAX(8'd200), .STEP_DIV(5)) dut_a (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .host(ifa.slave),
    .sweep_en(sweep_en), .sweep_mode(sweep_mode),
    .phinc(phinc_a), .phinc_upd(upd_a), .sweep_state(st_a));

  phinc_ctrl #(.DEFAULT(8'd2), .PHI_MIN(8'd1), .PHI_MAX(8'd4), .STEP_DIV(4)) dut_b (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_dn(btn_dn), .host(ifb.slave),
    .sweep_en(sweep_en), .sweep_mode(sweep_mode),
    .phinc(phinc_b), .phinc_upd(upd_b), .sweep_state(st_b));

  typedef struct {
    int phinc;
    bit upd;
    bit rdy;
    int st;
    bit saw;
    bit en_q;
    int age;
  } mdl_t;

  mdl_t m[2];
  int   lo[2]   = '{1, 1};
  int   hi[2]   = '{200, 4};
  int   dv[2]   = '{5, 4};
  int   dflt[2] = '{1, 2};

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // age counts cycles spent sweeping; every dv-th one carries a step
  function automatic mdl_t mstep(input mdl_t s, input int l, input int h, input int d,
                                 input bit up, input bit dn, input bit hv, input int hd,
                                 input bit en, input bit mode);
    mdl_t n    = s;
    bit   fire = hv && s.rdy;
    bit   man  = fire || up || dn;
    bit   rise = en && !s.en_q;
    bit   tick = (s.st != 0) && (s.age % d == d - 1);
    int   v    = s.phinc;
    if (fire)      v = (hd < l) ? l : ((hd > h) ? h : hd);
    else if (dn)   v = (s.phinc > l) ? s.phinc - 1 : l;
    else if (up)   v = (s.phinc < h) ? s.phinc + 1 : h;
    else if (tick && en) begin
      if (s.st == 1) begin
        if (s.phinc >= h) begin
          if (s.saw) v = l;
          else begin v = s.phinc - 1; n.st = 2; end
        end else v = s.phinc + 1;
      end else begin
        if (s.phinc <= l) begin v = s.phinc + 1; n.st = 1; end
        else v = s.phinc - 1;
      end
    end
    n.upd   = (v != s.phinc);
    n.phinc = v;
    n.rdy   = !fire;
    n.en_q  = en;
    if (!en || man) n.st = 0;
    else if (s.st == 0 && rise) begin
      n.st  = 1;
      n.saw = mode;
    end
    n.age = (n.st == 0 || s.st == 0) ? 0 : s.age + 1;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      m[i] = '{phinc: dflt[i], upd: 1'b0, rdy: 1'b1, st: 0, saw: 1'b0, en_q: 1'b0, age: 0};
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".a.phinc"}, int'(phinc_a),        m[0].phinc);
    check_val({tag, ".a.upd"},   int'(upd_a),          int'(m[0].upd));
    check_val({tag, ".a.ready"}, int'(ifa.host_ready), int'(m[0].rdy));
    check_val({tag, ".a.state"}, int'(st_a),           m[0].st);
    check_val({tag, ".b.phinc"}, int'(phinc_b),        m[1].phinc);
    check_val({tag, ".b.upd"},   int'(upd_b),          int'(m[1].upd));
    check_val({tag, ".b.ready"}, int'(ifb.host_ready), int'(m[1].rdy));
    check_val({tag, ".b.state"}, int'(st_b),           m[1].st);
  endtask

  task automatic cyc(input string tag, input bit up, input bit dn, input bit hv,
                     input logic [7:0] hd, input bit en, input bit mode);
    btn_up = up; btn_dn = dn; sweep_en = en; sweep_mode = mode;
    ifa.host_valid = hv; ifb.host_valid = hv;
    ifa.host_data  = hd; ifb.host_data  = hd;
    @(posedge clk);
    for (int i = 0; i < 2; i++)
      m[i] = mstep(m[i], lo[i], hi[i], dv[i], up, dn, hv, int'(hd), en, mode);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n, input bit en, input bit mode);
    for (int k = 0; k < n; k++) cyc(tag, 1'b0, 1'b0, 1'b0, 8'd0, en, mode);
  endtask

  task automatic hard_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b1;
  endtask

  initial begin
    ifa.host_valid = 1'b0; ifb.host_valid = 1'b0;
    ifa.host_data  = 8'd0; ifb.host_data  = 8'd0;
    #12;
    model_reset();
    check_all("reset");
    reset = 1'b1;

    for (int k = 0; k < 3; k++) begin
      cyc("btn_up", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      idle("btn_up_gap", 1, 1'b0, 1'b0);
    end
    for (int k = 0; k < 5; k++) cyc("btn_dn_sat", 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

    cyc("host_clamp", 1'b0, 1'b0, 1'b1, 8'd250, 1'b0, 1'b0);
    cyc("host_b2b_wait", 1'b0, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0);
    cyc("host_b2b_take", 1'b0, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0);
    cyc("host_eq", 1'b0, 1'b0, 1'b1, 8'd100, 1'b0, 1'b0);
    idle("gap", 1, 1'b0, 1'b0);
    cyc("host_beats_btn", 1'b1, 1'b0, 1'b1, 8'd50, 1'b0, 1'b0);
    cyc("btn_dropped", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("host_10", 1'b0, 1'b0, 1'b1, 8'd10, 1'b0, 1'b0);
    idle("gap", 1, 1'b0, 1'b0);
    cyc("dn_beats_up", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    cyc("host_zero", 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
    idle("gap", 1, 1'b0, 1'b0);

    idle("tri_sweep", 60, 1'b1, 1'b0);
    idle("sweep_off", 2, 1'b0, 1'b0);
    cyc("host_one", 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
    idle("saw_sweep", 30, 1'b1, 1'b1);
    cyc("override", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    idle("no_restart", 12, 1'b1, 1'b1);
    idle("toggle_low", 1, 1'b0, 1'b1);
    idle("restart", 7, 1'b1, 1'b0);
    hard_reset("rst_mid_sweep");
    idle("post_rst", 10, 1'b1, 1'b0);
    cyc("host_mid", 1'b0, 1'b0, 1'b1, 8'd77, 1'b1, 1'b0);
    hard_reset("rst_mid_hs");

    for (int k = 0; k < 3000; k++) begin
      bit en_r;
      en_r = sweep_en;
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      if ($urandom_range(0, 599) == 0) hard_reset("rand_rst");
      else cyc("rand",
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 7) == 0,
               8'($urandom_range(0, 255)),
               en_r,
               1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phinc_ctrl.md
# phinc_ctrl

Arbitrated controller for the 8-bit phase-increment register that drives the NCO/DDS datapath. Three requesters share the register: a host write port with a valid/ready handshake, single-cycle button pulses from the debounce front end, and an internal sweep engine. Priority is fixed: host, then buttons, then sweep. The block replaces direct button-driven increment logic. It adds range saturation, an auto-sweep mode and a change strobe for downstream phase accumulators.

## Interface
- DEFAULT, 8'd1, phinc value loaded at reset; must satisfy PHI_MIN ≤ DEFAULT ≤ PHI_MAX
- PHI_MIN, 8'd1, lower bound of phinc
- PHI_MAX, 8'd200, upper bound of phinc; PHI_MAX > PHI_MIN
- STEP_DIV, 10000, clk cycles per sweep step (≥2)
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- btn_up  in  1  one-cycle increment request, already synchronised and edge-detected
- btn_dn  in  1  one-cycle decrement request, already synchronised and edge-detected
- host_valid  in  1  host write request
- host_data  in  8  requested phinc value
- host_ready  out  1  host write accepted when host_valid && host_ready
- sweep_en  in  1  level; a rising edge starts the sweep
- sweep_mode  in  1  0 = triangle, 1 = sawtooth; sampled at sweep start
- phinc  out  8  registered phase increment
- phinc_upd  out  1  one-cycle strobe, high in the first cycle phinc holds a changed value
- sweep_state  out  2  current FSM state: 0 IDLE, 1 UP, 2 DN

## Operation
- Arbitration is evaluated each cycle. At most one update is applied per cycle.
  - A host transfer wins over everything else.
  - Otherwise btn_dn, then btn_up.
  - Otherwise a sweep step, if a tick is present.
- Host write: phinc ← host_data clamped to [PHI_MIN, PHI_MAX].
- Buttons: ±1 with saturation at PHI_MIN/PHI_MAX; no wrap-around. If btn_up and btn_dn are both high, btn_dn wins.
- A host transfer or button event while the FSM is UP or DN forces IDLE (manual override). The sweep restarts only on a new rising edge of sweep_en.
- A losing button pulse in the same cycle as a host transfer is dropped, not queued.
- Sweep FSM:
  - IDLE → UP on sweep_en rising edge. This also latches sweep_mode and clears the tick divider.
  - UP, on each tick: phinc+1. When phinc equals PHI_MAX at the tick:
    - triangle: → DN, and phinc−1 on that tick;
    - sawtooth: phinc ← PHI_MIN, stay UP.
  - DN, on each tick: phinc−1. When phinc equals PHI_MIN at the tick: → UP, and phinc+1.
  - Any state → IDLE when sweep_en is low.
- Tick: the divider counts 0…STEP_DIV−1 while the FSM is not IDLE. The tick is asserted when the count equals STEP_DIV−1, then the counter wraps to 0. The counter holds at 0 in IDLE.
- phinc_upd fires only if the new value differs from the old one, so a saturated button press or a clamped equal write gives no strobe.

## Timing
- Reset values: phinc = DEFAULT, phinc_upd = 0, host_ready = 1, sweep_state = IDLE, divider = 0, sweep_en edge register = 0.
- Latency: a request accepted in cycle N gives the new phinc and phinc_upd in cycle N+1.
- host_ready is registered. It is 0 in the cycle after a transfer and 1 in the cycle after that, so the host port sustains at most one write every 2 cycles.
- First sweep step occurs STEP_DIV cycles after the cycle in which the sweep_en rising edge is registered.
- Asserting reset mid-sweep or mid-handshake returns every output to its reset value immediately, with no partial update. An in-flight host write is lost.
- Widths: the divider is $clog2(STEP_DIV) bits. Arithmetic is 9-bit internally before clamping, so 8'hFF+1 can never wrap.

## Structure
- Package phinc_pkg holds:
  - the sweep state enum (IDLE, UP, DN) with 2-bit encoding;
  - the mode constants MODE_TRI = 0 and MODE_SAW = 1;
  - a clamp function.
- One sub-module, sweep_tick_gen: the STEP_DIV divider with enable and synchronous clear, producing a one-cycle tick.

## Test plan
- Reset, then 3×btn_up → phinc 1→2→3→4, with one phinc_upd per step. Then btn_dn with PHI_MIN=1 at phinc=1 → stays 1, no strobe.
- host_valid with data 8'd250 and PHI_MAX=200 → phinc=200 next cycle and host_ready=0 for one cycle. A second back-to-back valid is accepted one cycle later.
- Same-cycle host write 8'd50 and btn_up → phinc=50, button dropped. Same-cycle btn_up and btn_dn at 10 → 9.
- STEP_DIV=4, PHI_MIN=1, PHI_MAX=4, triangle from phinc=1:
  - phinc sequence 2,3,4,3,2,1,2…, one step every 4 cycles.
  - sweep_state reads 1, then 2 after hitting 4.
- Same limits, sawtooth: sequence 2,3,4,1,2…. A btn_up mid-sweep gives phinc+1 and IDLE; holding sweep_en high does not restart until it toggles low then high.
- Assert reset during the UP state with phinc=3 → phinc=DEFAULT, IDLE, host_ready=1, no phinc_upd.
